// File: rtl/pong_pkg.sv
// Shared constants for the pong game controller: state encoding, winner codes,
// BCD width, default timing, and a constant-time decimal-to-BCD helper.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam int BCD_W           = 8;
    localparam int DEF_WIN_SCORE   = 11;
    localparam int DEF_PAUSE_TICKS = 120;
    localparam int DEF_OVER_TICKS  = 180;

    // Used on parameters only, so the divide never reaches hardware.
    function automatic logic [BCD_W-1:0] to_bcd(input int value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(value / 10);
        ones = 4'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/pong_bcd_inc.sv
// Two-digit BCD incrementer that saturates at 99; sat flags an input of 99.
module pong_bcd_inc
    import pong_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic             sat
);

    always_comb begin
        sat     = (bcd_in == 8'h99);
        bcd_out = bcd_in;
        if (!sat) begin
            if (bcd_in[3:0] >= 4'd9) begin
                bcd_out = {bcd_in[7:4] + 4'd1, 4'd0};
            end else begin
                bcd_out = {bcd_in[7:4], bcd_in[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: scores, winner and ball freeze control.
// Optional rally counter output enabled by defining PONG_RALLY_COUNT_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int PAUSE_TICKS = DEF_PAUSE_TICKS,
    parameter int OVER_TICKS  = DEF_OVER_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refresh_tick,
    input  logic             btn_any,
    input  logic             miss_l,
    input  logic             miss_r,
    input  logic             hit,
    output logic             gra_still,
    output logic [BCD_W-1:0] score_l,
    output logic [BCD_W-1:0] score_r,
    output logic [1:0]       winner,
    output logic             game_over,
    output logic [1:0]       state_o
`ifdef PONG_RALLY_COUNT_EN
    ,
    output logic [BCD_W-1:0] rally_cnt
`endif
);

    localparam logic [BCD_W-1:0] WIN_BCD    = to_bcd(WIN_SCORE);
    localparam logic [7:0]       PAUSE_LOAD = 8'(PAUSE_TICKS);
    localparam logic [7:0]       OVER_LOAD  = 8'(OVER_TICKS);

    state_t           state_reg;
    logic             gra_still_reg;
    logic [BCD_W-1:0] score_reg [2];
    logic [1:0]       winner_reg;
    logic             game_over_reg;
    logic [7:0]       timer_reg;
    logic             btn_q_reg;

    logic [BCD_W-1:0] score_inc [2];
    logic [1:0]       inc_sat_unused;
    logic             btn_rise;
    logic             tick_expire;
    logic             point;
    logic             scorer;
    logic [BCD_W-1:0] point_bcd;
    logic             point_win;
    logic             over_exit;

    // Index 0 is the left player, index 1 the right player.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_score_inc
            pong_bcd_inc u_inc (
                .bcd_in  (score_reg[gi]),
                .bcd_out (score_inc[gi]),
                .sat     (inc_sat_unused[gi])
            );
        end
    endgenerate

    assign btn_rise    = btn_any & ~btn_q_reg;
    // A load of 0 or 1 both expire on the very next tick.
    assign tick_expire = refresh_tick && (timer_reg <= 8'd1);
    assign point       = miss_l | miss_r;
    // A left miss scores for the right player and takes priority.
    assign scorer      = miss_l;
    assign point_bcd   = score_inc[scorer];
    assign point_win   = (point_bcd == WIN_BCD);
    assign over_exit   = btn_rise || tick_expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_NEWGAME;
            gra_still_reg <= 1'b1;
            score_reg[0]  <= '0;
            score_reg[1]  <= '0;
            winner_reg    <= WIN_NONE;
            game_over_reg <= 1'b0;
            timer_reg     <= '0;
            btn_q_reg     <= 1'b0;
        end else begin
            btn_q_reg <= btn_any;
            case (state_reg)
                ST_NEWGAME: begin
                    if (btn_rise) begin
                        state_reg     <= ST_PLAY;
                        gra_still_reg <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    // Leaving PLAY on the same edge as the increment stops a held miss double-counting.
                    if (point) begin
                        score_reg[scorer] <= point_bcd;
                        gra_still_reg     <= 1'b1;
                        if (point_win) begin
                            winner_reg    <= scorer ? WIN_RIGHT : WIN_LEFT;
                            timer_reg     <= OVER_LOAD;
                            game_over_reg <= 1'b1;
                            state_reg     <= ST_OVER;
                        end else begin
                            timer_reg <= PAUSE_LOAD;
                            state_reg <= ST_NEWBALL;
                        end
                    end
                end
                ST_NEWBALL: begin
                    if (tick_expire) begin
                        timer_reg     <= '0;
                        state_reg     <= ST_PLAY;
                        gra_still_reg <= 1'b0;
                    end else if (refresh_tick) begin
                        timer_reg <= timer_reg - 8'd1;
                    end
                end
                ST_OVER: begin
                    if (over_exit) begin
                        timer_reg     <= '0;
                        score_reg[0]  <= '0;
                        score_reg[1]  <= '0;
                        winner_reg    <= WIN_NONE;
                        game_over_reg <= 1'b0;
                        state_reg     <= ST_NEWGAME;
                    end else if (refresh_tick) begin
                        timer_reg <= timer_reg - 8'd1;
                    end
                end
                default: state_reg <= ST_NEWGAME;
            endcase
        end
    end

    assign gra_still = gra_still_reg;
    assign score_l   = score_reg[0];
    assign score_r   = score_reg[1];
    assign winner    = winner_reg;
    assign game_over = game_over_reg;
    assign state_o   = state_reg;

`ifdef PONG_RALLY_COUNT_EN
    logic             hit_q_reg;
    logic [BCD_W-1:0] rally_reg;
    logic [BCD_W-1:0] rally_inc;
    logic             rally_sat_unused;
    logic             rally_clear;

    pong_bcd_inc u_rally_inc (
        .bcd_in  (rally_reg),
        .bcd_out (rally_inc),
        .sat     (rally_sat_unused)
    );

    // Cleared on entry to NEWBALL or NEWGAME; a point that wins keeps the count.
    assign rally_clear = ((state_reg == ST_PLAY) && point && !point_win) ||
                         ((state_reg == ST_OVER) && over_exit);

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q_reg <= 1'b0;
            rally_reg <= '0;
        end else begin
            hit_q_reg <= hit;
            if (rally_clear) begin
                rally_reg <= '0;
            end else if ((state_reg == ST_PLAY) && !point && hit && !hit_q_reg) begin
                rally_reg <= rally_inc;
            end
        end
    end

    assign rally_cnt = rally_reg;
`else
    logic hit_unused;
    assign hit_unused = hit;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized and directed bench for pong_game_ctrl against a tick-counting game model.
module tb_pong_game_ctrl;

    localparam int WIN   = 10;
    localparam int PAUSE = 120;
    localparam int OVER  = 180;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       refresh_tick = 1'b0;
    logic       btn_any = 1'b0;
    logic       miss_l = 1'b0;
    logic       miss_r = 1'b0;
    logic       hit = 1'b0;
    logic       gra_still;
    logic [7:0] score_l;
    logic [7:0] score_r;
    logic [1:0] winner;
    logic       game_over;
    logic [1:0] state_o;
`ifdef PONG_RALLY_COUNT_EN
    logic [7:0] rally_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model: state 0 newgame, 1 play, 2 newball, 3 over; scores in plain decimal.
    int m_state = 0;
    int m_sl = 0;
    int m_sr = 0;
    int m_win = 0;
    int m_seen = 0;
    int m_rally = 0;
    bit m_btn_q = 0;
    bit m_hit_q = 0;

    pong_game_ctrl #(
        .WIN_SCORE   (WIN),
        .PAUSE_TICKS (PAUSE),
        .OVER_TICKS  (OVER)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .btn_any      (btn_any),
        .miss_l       (miss_l),
        .miss_r       (miss_r),
        .hit          (hit),
        .gra_still    (gra_still),
        .score_l      (score_l),
        .score_r      (score_r),
        .winner       (winner),
        .game_over    (game_over),
        .state_o      (state_o)
`ifdef PONG_RALLY_COUNT_EN
        ,
        .rally_cnt    (rally_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dec2bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic int sat99(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    function automatic logic [21:0] exp_vec();
        return {2'(m_state), (m_state != 1), dec2bcd(m_sl), dec2bcd(m_sr),
                2'(m_win), (m_state == 3)};
    endfunction

    task automatic model_update(input bit rst, input bit b, input bit ml,
                                input bit mr, input bit h, input bit t);
        bit rise;
        bit hrise;
        rise  = b && !m_btn_q;
        hrise = h && !m_hit_q;
        if (rst) begin
            m_state = 0; m_sl = 0; m_sr = 0; m_win = 0; m_seen = 0;
            m_rally = 0; m_btn_q = 0; m_hit_q = 0;
            return;
        end
        case (m_state)
            0: if (rise) m_state = 1;
            1: begin
                if (ml || mr) begin
                    m_seen = 0;
                    if (ml) m_sr = sat99(m_sr + 1);
                    else    m_sl = sat99(m_sl + 1);
                    if (ml && m_sr == WIN) begin
                        m_win = 2; m_state = 3;
                    end else if (!ml && m_sl == WIN) begin
                        m_win = 1; m_state = 3;
                    end else begin
                        m_state = 2; m_rally = 0;
                    end
                end else if (hrise) begin
                    m_rally = sat99(m_rally + 1);
                end
            end
            2: if (t) begin
                m_seen++;
                if (m_seen >= ((PAUSE > 0) ? PAUSE : 1)) m_state = 1;
            end
            default: begin
                if (t) m_seen++;
                if (rise || (t && m_seen >= ((OVER > 0) ? OVER : 1))) begin
                    m_state = 0; m_sl = 0; m_sr = 0; m_win = 0; m_rally = 0;
                end
            end
        endcase
        m_btn_q = b;
        m_hit_q = h;
    endtask

    task automatic step(input bit rst, input bit b, input bit ml, input bit mr,
                        input bit h, input bit t);
        reset = rst; btn_any = b; miss_l = ml; miss_r = mr; hit = h; refresh_tick = t;
        @(posedge clk);
        model_update(rst, b, ml, mr, h, t);
        #1;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            step(0, 0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if ({state_o, gra_still, score_l, score_r, winner, game_over} !== {2'b00, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got state=%b still=%b L=%h R=%h win=%b over=%b, want 00 1 00 00 00 0",
                     state_o, gra_still, score_l, score_r, winner, game_over);
        end
        step(0, 0, 0, 0, 0, 0);
        $display("test_reset: state=%b still=%b", state_o, gra_still);
    endtask

    task automatic test_start();
        step(0, 1, 0, 0, 0, 0);
        checks++;
        if (state_o !== 2'b01 || gra_still !== 1'b0) begin
            errors++;
            $display("FAIL start_play: got state=%b still=%b, want 01 0", state_o, gra_still);
        end
        step(0, 0, 0, 0, 0, 0);
        $display("test_start: state=%b still=%b", state_o, gra_still);
    endtask

    task automatic test_miss_held();
        int changes;
        logic [7:0] last;
        changes = 0;
        last = score_r;
        for (int i = 0; i < 500; i++) begin
            step(0, 0, 1, 0, 0, 0);
            if (score_r !== last) changes++;
            last = score_r;
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (changes != 1 || score_r !== 8'h01 || state_o !== 2'b10) begin
            errors++;
            $display("FAIL miss_held: got changes=%0d R=%h state=%b, want 1 01 10", changes, score_r, state_o);
        end
        run_ticks(PAUSE - 1);
        checks++;
        if (state_o !== 2'b10) begin
            errors++;
            $display("FAIL pause_early: got state=%b, want 10", state_o);
        end
        run_ticks(1);
        checks++;
        if (state_o !== 2'b01 || gra_still !== 1'b0) begin
            errors++;
            $display("FAIL pause_end: got state=%b still=%b, want 01 0", state_o, gra_still);
        end
        $display("test_miss_held: L=%h R=%h state=%b", score_l, score_r, state_o);
    endtask

    task automatic test_both_miss();
        step(0, 0, 1, 1, 0, 0);
        checks++;
        if (score_r !== 8'h02 || score_l !== 8'h00) begin
            errors++;
            $display("FAIL both_miss: got L=%h R=%h, want 00 02", score_l, score_r);
        end
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        checks++;
        if (state_o !== 2'b10) begin
            errors++;
            $display("FAIL newball_btn: got state=%b, want 10", state_o);
        end
        run_ticks(PAUSE);
        $display("test_both_miss: L=%h R=%h state=%b", score_l, score_r, state_o);
    endtask

    task automatic test_bcd_carry_win();
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0, 0);
            run_ticks(PAUSE);
        end
        checks++;
        if (score_l !== 8'h09 || state_o !== 2'b01) begin
            errors++;
            $display("FAIL score_nine: got L=%h state=%b, want 09 01", score_l, state_o);
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (score_l !== 8'h10 || winner !== 2'b01 || game_over !== 1'b1 || state_o !== 2'b11) begin
            errors++;
            $display("FAIL bcd_win: got L=%h win=%b over=%b state=%b, want 10 01 1 11",
                     score_l, winner, game_over, state_o);
        end
        step(0, 0, 0, 0, 0, 0);
        $display("test_bcd_carry_win: L=%h R=%h winner=%b", score_l, score_r, winner);
    endtask

    task automatic test_over_timeout();
        run_ticks(OVER - 1);
        checks++;
        if (state_o !== 2'b11 || winner !== 2'b01) begin
            errors++;
            $display("FAIL over_hold: got state=%b win=%b, want 11 01", state_o, winner);
        end
        run_ticks(1);
        checks++;
        if ({state_o, gra_still, score_l, score_r, winner, game_over} !== {2'b00, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL over_exit: got state=%b still=%b L=%h R=%h win=%b over=%b, want 00 1 00 00 00 0",
                     state_o, gra_still, score_l, score_r, winner, game_over);
        end
        $display("test_over_timeout: state=%b", state_o);
    endtask

    task automatic test_reset_mid();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, (i >= 5), (i < 5), 0, 0);
            step(0, 0, 0, 0, 0, 0);
            run_ticks(PAUSE);
        end
        checks++;
        if (score_l !== 8'h05 || score_r !== 8'h07 || state_o !== 2'b01) begin
            errors++;
            $display("FAIL mid_scores: got L=%h R=%h state=%b, want 05 07 01", score_l, score_r, state_o);
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (state_o !== 2'b00 || score_l !== 8'h00 || score_r !== 8'h00 || gra_still !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got state=%b L=%h R=%h still=%b, want 00 00 00 1",
                     state_o, score_l, score_r, gra_still);
        end
        step(0, 0, 0, 0, 0, 0);
        $display("test_reset_mid: state=%b L=%h R=%h", state_o, score_l, score_r);
    endtask

`ifdef PONG_RALLY_COUNT_EN
    task automatic test_rally();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (rally_cnt !== 8'h02) begin
            errors++;
            $display("FAIL rally_two: got %h, want 02", rally_cnt);
        end
        step(0, 0, 1, 0, 0, 0);
        checks++;
        if (rally_cnt !== 8'h00 || state_o !== 2'b10) begin
            errors++;
            $display("FAIL rally_clear: got rally=%h state=%b, want 00 10", rally_cnt, state_o);
        end
        step(0, 0, 0, 0, 0, 0);
        run_ticks(PAUSE);
        $display("test_rally: rally=%h state=%b", rally_cnt, state_o);
    endtask
`endif

    task automatic test_random();
        int last_pts;
        bit b, ml, mr, h, t, r;
        int bad;
        bad = 0;
        last_pts = m_sl + m_sr;
        for (int i = 0; i < 20000; i++) begin
            r  = ($urandom_range(0, 2999) == 0);
            b  = ($urandom_range(0, 39) == 0);
            ml = ($urandom_range(0, 29) == 0);
            mr = ($urandom_range(0, 29) == 0);
            h  = ($urandom_range(0, 5) == 0);
            t  = $urandom_range(0, 1) == 1;
            step(r, b, ml, mr, h, t);
            checks++;
            if ({state_o, gra_still, score_l, score_r, winner, game_over} !== exp_vec()) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle %0d: got %h, want %h", i,
                             {state_o, gra_still, score_l, score_r, winner, game_over}, exp_vec());
            end
`ifdef PONG_RALLY_COUNT_EN
            checks++;
            if (rally_cnt !== dec2bcd(m_rally)) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_rally %0d: got %h, want %h", i, rally_cnt, dec2bcd(m_rally));
            end
`endif
            if (m_sl + m_sr != last_pts) begin
                if (m_sl + m_sr > last_pts)
                    $display("point: cycle=%0d L=%h R=%h winner=%b", i, score_l, score_r, winner);
                last_pts = m_sl + m_sr;
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_miss_held();
        test_both_miss();
        test_bcd_carry_win();
        test_over_timeout();
        test_reset_mid();
`ifdef PONG_RALLY_COUNT_EN
        test_rally();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
